i2c_target_rx: RTL and testbench

- Target-side (responder) receiver for the team's I2C controller. It is the other end of the bus driven by the controller's bit timer and shift logic.
- Filters and synchronises SCL/SDA, detects START/STOP, and shifts in the address byte; ACKs on a 7-bit address match with R/W=0.
- Receives write data bytes, ACKs each one, and presents each byte to the local register file with a one-cycle valid pulse.
- Read transfers (R/W=1) are NACKed; this block is write-only.

---
 rtl/i2c_target_rx_if.sv | 21 ++
 rtl/i2c_target_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_rx_if.sv
// Bus-side and local-sink signals of the write-only I2C target receiver.
// slave = the target (i2c_target_rx); master = whoever drives the bus lines and consumes bytes.
interface i2c_target_rx_if;
  logic       Scl_i;
  logic       Sda_i;
  logic       Rx_ready;
  logic       Sda_oe;
  logic       Scl_oe;
  logic [7:0] Rx_data;
  logic       Rx_valid;

  modport slave (
    input  Scl_i, Sda_i, Rx_ready,
    output Sda_oe, Scl_oe, Rx_data, Rx_valid
  );

  modport master (
    output Scl_i, Sda_i, Rx_ready,
    input  Sda_oe, Scl_oe, Rx_data, Rx_valid
  );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: filters SCL/SDA, detects START/STOP, ACKs its 7-bit address and data bytes.
// Optional clock stretching on a busy sink is enabled by defining I2C_TGT_STRETCH_EN.
module i2c_target_rx #(
  parameter int FILT_LEN = 3,
  parameter int FILT_W   = 2
) (
  input  logic           Clk,
  input  logic           Rst_n,
  i2c_target_rx_if.slave bus,
  input  logic [6:0]     Own_addr,
  output logic           Start_det,
  output logic           Stop_det,
  output logic           Busy,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  // Index 0 is SCL, index 1 is SDA throughout the input path.
  logic [1:0]        sync1;
  logic [1:0]        sync2;
  logic [1:0]        filt;
  logic [1:0]        filt_d;
  logic [FILT_W-1:0] fcnt [2];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      filt_d  <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1  <= {bus.Sda_i, bus.Scl_i};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_W'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FILT_W'(1);
        end
      end
    end
  end

  logic scl_f;
  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic sda_rise;
  logic sda_fall;
  logic start_cond;
  logic stop_cond;

  assign scl_f      = filt[0];
  assign sda_f      = filt[1];
  assign scl_rise   = filt[0] & ~filt_d[0];
  assign scl_fall   = ~filt[0] & filt_d[0];
  assign sda_rise   = filt[1] & ~filt_d[1];
  assign sda_fall   = ~filt[1] & filt_d[1];
  assign start_cond = sda_fall & scl_f;
  assign stop_cond  = sda_rise & scl_f;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] rx_data, rx_data_n;
  logic       rx_valid, rx_valid_n;
  logic       sda_oe, sda_oe_n;
  logic       start_q, start_n;
  logic       stop_q, stop_n;
  logic       busy, busy_n;
  logic [7:0] byte_in;
`ifdef I2C_TGT_STRETCH_EN
  logic       scl_oe, scl_oe_n;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shift    <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      sda_oe   <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      busy     <= 1'b0;
`ifdef I2C_TGT_STRETCH_EN
      scl_oe   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      sda_oe   <= sda_oe_n;
      start_q  <= start_n;
      stop_q   <= stop_n;
      busy     <= busy_n;
`ifdef I2C_TGT_STRETCH_EN
      scl_oe   <= scl_oe_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shift_n    = shift;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    sda_oe_n   = sda_oe;
    start_n    = 1'b0;
    stop_n     = 1'b0;
    busy_n     = busy;
    byte_in    = {shift[6:0], sda_f};
`ifdef I2C_TGT_STRETCH_EN
    scl_oe_n   = scl_oe;
`endif

    if (start_cond) begin
      start_n  = 1'b1;
      busy_n   = 1'b1;
      cnt_n    = 4'd0;
      sda_oe_n = 1'b0;
      state_n  = ADDR;
`ifdef I2C_TGT_STRETCH_EN
      scl_oe_n = 1'b0;
`endif
    end else if (stop_cond) begin
      stop_n   = 1'b1;
      busy_n   = 1'b0;
      sda_oe_n = 1'b0;
      state_n  = IDLE;
`ifdef I2C_TGT_STRETCH_EN
      scl_oe_n = 1'b0;
`endif
    end else begin
`ifdef I2C_TGT_STRETCH_EN
      if (scl_oe && bus.Rx_ready) begin
        scl_oe_n = 1'b0;
      end
`endif
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n = byte_in;
            if (cnt == 4'd7) begin
              cnt_n = 4'd8;
              if ((byte_in[7:1] == Own_addr) && !byte_in[0]) begin
                state_n = ADDR_ACK;
              end else begin
                state_n = IGNORE;
              end
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (scl_rise) begin
            shift_n = byte_in;
            if (cnt == 4'd7) begin
              cnt_n      = 4'd8;
              rx_data_n  = byte_in;
              rx_valid_n = 1'b1;
              state_n    = DATA_ACK;
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end
        // First SCL fall after the 8th bit drives ACK; the next fall releases it.
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
`ifdef I2C_TGT_STRETCH_EN
              if ((state == DATA_ACK) && !bus.Rx_ready) begin
                scl_oe_n = 1'b1;
              end
`endif
            end else begin
              sda_oe_n = 1'b0;
              cnt_n    = 4'd0;
              state_n  = DATA;
            end
          end
        end
        IGNORE: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

`ifdef I2C_TGT_STRETCH_EN
  assign bus.Scl_oe = scl_oe;
`else
  logic unused_rx_ready;
  assign unused_rx_ready = bus.Rx_ready;
  assign bus.Scl_oe      = 1'b0;
`endif

  assign bus.Sda_oe   = sda_oe;
  assign bus.Rx_data  = rx_data;
  assign bus.Rx_valid = rx_valid;
  assign Start_det    = start_q;
  assign Stop_det     = stop_q;
  assign Busy         = busy;
  assign dbg_state    = state;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: open-drain bus model, byte scoreboard, pulse counters.
module tb_i2c_target_rx;

  localparam int HALF = 20;
  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd3, S_IGNORE = 3'd5;

  logic       clk;
  logic       rst_n;
  logic       scl_drv;
  logic       sda_drv;
  logic       rx_ready;
  logic [6:0] own_addr;
  logic       start_det;
  logic       stop_det;
  logic       busy;
  logic [2:0] dbg_state;

  i2c_target_rx_if bus_if ();

  // Open-drain wired-AND of the controller drive and the target pull-downs.
  assign bus_if.Scl_i    = scl_drv & ~bus_if.Scl_oe;
  assign bus_if.Sda_i    = sda_drv & ~bus_if.Sda_oe;
  assign bus_if.Rx_ready = rx_ready;

  i2c_target_rx #(.FILT_LEN(3), .FILT_W(2)) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .bus       (bus_if.slave),
    .Own_addr  (own_addr),
    .Start_det (start_det),
    .Stop_det  (stop_det),
    .Busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard and counters
  int vectors = 0;
  int miscompares = 0;
  int n_start = 0;
  int n_stop = 0;
  int n_valid = 0;
  int oe_bad = 0;
  int scl_oe_seen = 0;
  logic [7:0] exp_q[$];
  logic prev_oe = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (start_det) n_start++;
      if (stop_det) n_stop++;
      if (bus_if.Scl_oe) scl_oe_seen++;
      if (bus_if.Rx_valid) begin
        n_valid++;
        if (exp_q.size() > 0) check("rx_data_sb", bus_if.Rx_data, exp_q.pop_front());
      end
      if ((bus_if.Sda_oe !== prev_oe) && bus_if.Scl_i) oe_bad++;
      prev_oe = bus_if.Sda_oe;
    end else begin
      prev_oe = 1'b0;
    end
  end

  // Driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    int n;
    n = 0;
    scl_drv = 1'b1;
    while ((bus_if.Scl_i !== 1'b1) && (n < 2000)) begin
      wait_clk(1);
      n++;
    end
    if (bus_if.Scl_i !== 1'b1) check("scl_release_timeout", bus_if.Scl_i, 1);
    wait_clk(HALF);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1;
    wait_clk(HALF);
    scl_up();
    sda_drv = 1'b0;
    wait_clk(HALF);
    scl_drv = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0;
    wait_clk(HALF);
    scl_up();
    sda_drv = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = b[i];
      wait_clk(HALF);
      scl_up();
      scl_drv = 1'b0;
    end
  endtask

  task automatic ack_bit(output logic ack);
    sda_drv = 1'b1;
    wait_clk(HALF);
    scl_up();
    ack = bus_if.Sda_oe & ~bus_if.Sda_i;
    scl_drv = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    ack_bit(ack);
  endtask

  // Directed vectors
  initial begin
    logic ack;
    int s0, p0, v0;
    scl_drv  = 1'b1;
    sda_drv  = 1'b1;
    rx_ready = 1'b1;
    own_addr = 7'h42;
    rst_n    = 1'b0;
    wait_clk(4);
    check("rst_sda_oe", bus_if.Sda_oe, 0);
    check("rst_scl_oe", bus_if.Scl_oe, 0);
    check("rst_rx_data", bus_if.Rx_data, 8'h00);
    check("rst_rx_valid", bus_if.Rx_valid, 0);
    check("rst_start_det", start_det, 0);
    check("rst_stop_det", stop_det, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    wait_clk(10);
    check("idle_no_start", n_start, 0);

    // Address match, one data byte
    s0 = n_start; p0 = n_stop; v0 = n_valid;
    i2c_start();
    check("t1_busy", busy, 1);
    check("t1_state_addr", dbg_state, S_ADDR);
    send_byte(8'h84, ack);
    check("t1_addr_ack", ack, 1);
    check("t1_state_data", dbg_state, S_DATA);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, ack);
    check("t1_data_ack", ack, 1);
    check("t1_rx_data", bus_if.Rx_data, 8'hA5);
    i2c_stop();
    check("t1_starts", n_start - s0, 1);
    check("t1_stops", n_stop - p0, 1);
    check("t1_valids", n_valid - v0, 1);
    check("t1_busy_end", busy, 0);
    check("t1_state_end", dbg_state, S_IDLE);

    // Wrong address
    v0 = n_valid;
    i2c_start();
    send_byte(8'h86, ack);
    check("t2_addr_nack", ack, 0);
    check("t2_state", dbg_state, S_IGNORE);
    send_byte(8'h11, ack);
    check("t2_data_nack", ack, 0);
    check("t2_state_hold", dbg_state, S_IGNORE);
    i2c_stop();
    check("t2_valids", n_valid - v0, 0);
    check("t2_state_end", dbg_state, S_IDLE);
    check("t2_rx_data_hold", bus_if.Rx_data, 8'hA5);

    // Read request is refused
    v0 = n_valid;
    i2c_start();
    send_byte(8'h85, ack);
    check("t3_read_nack", ack, 0);
    check("t3_state", dbg_state, S_IGNORE);
    i2c_stop();
    check("t3_valids", n_valid - v0, 0);

    // Partial byte aborted by repeated START
    s0 = n_start; v0 = n_valid;
    i2c_start();
    send_byte(8'h84, ack);
    check("t4_addr_ack", ack, 1);
    send_bits(8'hF0, 4);
    i2c_start();
    check("t4_rx_data_hold", bus_if.Rx_data, 8'hA5);
    send_byte(8'h84, ack);
    check("t4_addr2_ack", ack, 1);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, ack);
    check("t4_data_ack", ack, 1);
    i2c_stop();
    check("t4_starts", n_start - s0, 2);
    check("t4_valids", n_valid - v0, 1);
    check("t4_rx_data", bus_if.Rx_data, 8'h3C);

    // SDA glitch filtering while SCL high
    s0 = n_start; p0 = n_stop;
    sda_drv = 1'b0;
    wait_clk(1);
    sda_drv = 1'b1;
    wait_clk(HALF);
    check("t5_glitch_start", n_start - s0, 0);
    check("t5_glitch_stop", n_stop - p0, 0);
    check("t5_glitch_state", dbg_state, S_IDLE);
    sda_drv = 1'b0;
    wait_clk(5);
    sda_drv = 1'b1;
    wait_clk(HALF);
    check("t5_pulse_start", n_start - s0, 1);
    check("t5_pulse_stop", n_stop - p0, 1);
    check("t5_pulse_busy", busy, 0);

    // Busy sink
    v0 = n_valid;
    i2c_start();
    send_byte(8'h84, ack);
    check("t6_addr_ack", ack, 1);
    rx_ready = 1'b0;
    exp_q.push_back(8'h5A);
`ifdef I2C_TGT_STRETCH_EN
    send_bits(8'h5A, 8);
    wait_clk(8);
    check("t6_scl_oe_on", bus_if.Scl_oe, 1);
    check("t6_sda_oe_on", bus_if.Sda_oe, 1);
    wait_clk(12);
    rx_ready = 1'b1;
    wait_clk(1);
    check("t6_scl_oe_off", bus_if.Scl_oe, 0);
    ack_bit(ack);
    check("t6_data_ack", ack, 1);
`else
    scl_oe_seen = 0;
    send_byte(8'h5A, ack);
    check("t6_data_ack", ack, 1);
    check("t6_no_stretch", scl_oe_seen, 0);
    rx_ready = 1'b1;
`endif
    check("t6_rx_data", bus_if.Rx_data, 8'h5A);
    i2c_stop();
    check("t6_valids", n_valid - v0, 1);

    // Reset mid-acknowledge, then no re-arm without START
    i2c_start();
    send_bits(8'h84, 8);
    wait_clk(10);
    check("t7_ack_before_rst", bus_if.Sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_sda_oe", bus_if.Sda_oe, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_state", dbg_state, S_IDLE);
    check("t7_rst_rx_data", bus_if.Rx_data, 8'h00);
    wait_clk(3);
    rst_n = 1'b1;
    sda_drv = 1'b1;
    wait_clk(HALF);
    v0 = n_valid;
    send_byte(8'h84, ack);
    check("t7_no_rearm_ack", ack, 0);
    check("t7_no_rearm_state", dbg_state, S_IDLE);
    scl_up();

    // General call only when Own_addr is zero
    i2c_start();
    send_byte(8'h00, ack);
    check("t8_gc_nack", ack, 0);
    i2c_stop();
    own_addr = 7'h00;
    i2c_start();
    send_byte(8'h00, ack);
    check("t8_gc_ack", ack, 1);
    i2c_stop();
    check("t8_valids", n_valid - v0, 0);

    check("oe_change_scl_high", oe_bad, 0);
    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
